alu_arbiter: RTL

Shares one combinational ALU between two requesters: the main datapath (port 0) and an auxiliary address/compare unit (port 1). Each requester presents a decoded-instruction operation (ALU op class, funct7 bit 5, funct3) plus two operands through a valid/ready handshake. The block arbitrates round-robin, translates the operation to the 4-bit ALU control code, drives the shared ALU for one cycle, and returns the registered result to the winning requester through a second valid/ready handshake.

---
 rtl/alu_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// It decodes the requested operation, runs the ALU for one cycle and returns the registered result.
module alu_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0][1:0]        req_aluop,
   input  logic [1:0]             req_funct7,
   input  logic [1:0][2:0]        req_funct3,
   input  logic [1:0][WIDTH-1:0]  req_a,
   input  logic [1:0][WIDTH-1:0]  req_b,
   output logic [1:0]             resp_valid,
   input  logic [1:0]             resp_ready,
   output logic [WIDTH-1:0]       resp_data,
   output logic                   resp_err,
   output logic [WIDTH-1:0]       alu_a,
   output logic [WIDTH-1:0]       alu_b,
   output logic [3:0]             alu_ctrl,
   input  logic [WIDTH-1:0]       alu_result
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state_q;
   logic             id_q;
   logic             last_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [3:0]       ctrl_q;
   logic             illegal_q;

   logic             grant_id;
   logic [4:0]       dec_sel;

   // Returns {illegal, ctrl}; an illegal key already carries the add code the ALU must see.
   function automatic logic [4:0] decode(input logic [1:0] aluop, input logic f7,
                                         input logic [2:0] f3);
      logic [3:0] key;
      key = {f7, f3};
      decode = 5'b1_0010;
      case (aluop)
         2'b00: decode = 5'b0_0010;
         2'b01: decode = 5'b0_0110;
         default: begin
            case (key)
               4'b0000: decode = 5'b0_0010;
               4'b1000: decode = (aluop == 2'b11) ? 5'b1_0010 : 5'b0_0110;
               4'b0111: decode = 5'b0_0000;
               4'b0110: decode = 5'b0_0001;
               4'b0001: decode = 5'b0_0011;
               4'b0010: decode = 5'b0_0100;
               4'b0011: decode = 5'b0_0101;
               4'b0100: decode = 5'b0_0111;
               4'b0101: decode = 5'b0_1000;
               4'b1101: decode = 5'b0_1010;
               default: decode = 5'b1_0010;
            endcase
         end
      endcase
   endfunction

   // NOTE: every combinational output gets a default first, so no latch can be inferred.
   always_comb begin
      grant_id = 1'b0;
      if (req_valid == 2'b10)
         grant_id = 1'b1;
      else if (req_valid == 2'b11)
         grant_id = ~last_q;
      req_ready = 2'b00;
      if (state_q == IDLE && !reset && req_valid != 2'b00)
         req_ready = grant_id ? 2'b10 : 2'b01;
      dec_sel = decode(req_aluop[grant_id], req_funct7[grant_id], req_funct3[grant_id]);
   end

   always_comb begin
      alu_a      = '0;
      alu_b      = '0;
      alu_ctrl   = 4'b0000;
      resp_valid = 2'b00;
      if (state_q == EXEC) begin
         alu_a    = a_q;
         alu_b    = b_q;
         alu_ctrl = ctrl_q;
      end
      if (state_q == RESP)
         resp_valid = id_q ? 2'b10 : 2'b01;
   end

   // NOTE: state uses non-blocking assignments; the whole datapath is cleared on reset so
   // outputs never show stale operands after an aborted operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         id_q      <= 1'b0;
         last_q    <= 1'b1;
         a_q       <= '0;
         b_q       <= '0;
         ctrl_q    <= 4'b0000;
         illegal_q <= 1'b0;
         resp_data <= '0;
         resp_err  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if ((req_valid & req_ready) != 2'b00) begin
                  id_q      <= grant_id;
                  a_q       <= req_a[grant_id];
                  b_q       <= req_b[grant_id];
                  ctrl_q    <= dec_sel[3:0];
                  illegal_q <= dec_sel[4];
                  state_q   <= EXEC;
               end
            end
            EXEC: begin
               resp_data <= illegal_q ? '0 : alu_result;
               resp_err  <= illegal_q;
               last_q    <= id_q;
               state_q   <= RESP;
            end
            RESP: begin
               if (resp_ready[id_q])
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
